// File: rtl/chacha_qr_pkg.sv
// chacha_qr_pkg: shared state encoding and tile pin_ctrl layout for the quarter-round host
package chacha_qr_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, GO, SETTLE, WAIT, READ, DONE} state_t;
  localparam int CTRL_WR = 0;
  localparam int CTRL_RD = 1;
  localparam int CTRL_SEL_LSB = 2;
  localparam int CTRL_BYTE_LSB = 4;
  localparam int CTRL_GO = 6;
  localparam int WORD_A = 0;
  localparam int WORD_B = 1;
  localparam int WORD_C = 2;
  localparam int WORD_D = 3;
  function automatic logic [7:0] sel_bits(input logic [3:0] idx);
    logic [7:0] c;
    c = '0;
    c[CTRL_SEL_LSB +: 2] = idx[3:2];
    c[CTRL_BYTE_LSB +: 2] = idx[1:0];
    return c;
  endfunction
endpackage

// File: rtl/chacha_qr_host.sv
// chacha_qr_host: serializes a quarter-round request onto the tile byte pins and collects the result
module chacha_qr_host
  import chacha_qr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [31:0] in_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_c,
  output logic [31:0] out_d,
  output logic        out_err,
  output logic [7:0]  pin_data,
  output logic [7:0]  pin_ctrl,
  input  logic [7:0]  pin_result,
  input  logic        pin_busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 32);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] L_LAST = CW'(15);
  localparam logic [CW-1:0] R_LAST = CW'(16);
  localparam logic [7:0] WR_M = 8'(1 << CTRL_WR);
  localparam logic [7:0] RD_M = 8'(1 << CTRL_RD);
  localparam logic [7:0] GO_M = 8'(1 << CTRL_GO);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [127:0] sr, sr_d, res, res_d;
  logic err, err_d;
  logic [7:0] pin_data_d, pin_ctrl_d;
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign out_err = err;
  assign out_a = res[WORD_A*32 +: 32];
  assign out_b = res[WORD_B*32 +: 32];
  assign out_c = res[WORD_C*32 +: 32];
  assign out_d = res[WORD_D*32 +: 32];
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    sr_d = sr;
    res_d = res;
    err_d = err;
    case (state)
      IDLE: if (in_valid) begin
        state_d = LOAD;
        sr_d = {in_d, in_c, in_b, in_a};
        cnt_d = '0;
      end
      LOAD: begin
        sr_d = sr >> 8;
        cnt_d = cnt == L_LAST ? '0 : cnt + 1'b1;
        state_d = cnt == L_LAST ? GO : LOAD;
      end
      GO: begin
        state_d = SETTLE;
        cnt_d = '0;
      end
      SETTLE: begin
        cnt_d = cnt == S_LAST ? '0 : cnt + 1'b1;
        state_d = cnt == S_LAST ? WAIT : SETTLE;
      end
      WAIT: begin
        // a falling busy takes priority over a timeout expiring in the same cycle
        if (!pin_busy) begin
          state_d = READ;
          cnt_d = '0;
        end else if (cnt == T_LAST) begin
          state_d = DONE;
          err_d = 1'b1;
          res_d = '0;
        end else cnt_d = cnt + 1'b1;
      end
      READ: begin
        // uo_out lags RD by one cycle, so byte k lands while byte k+1 is requested
        res_d = cnt != '0 ? {pin_result, res[127:8]} : res;
        cnt_d = cnt + 1'b1;
        state_d = cnt == R_LAST ? DONE : READ;
        err_d = cnt == R_LAST ? 1'b0 : err;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    pin_data_d = state_d == LOAD ? sr_d[7:0] : '0;
    pin_ctrl_d = state_d == LOAD ? sel_bits(cnt_d[3:0]) | WR_M :
                 state_d == READ && cnt_d < R_LAST ? sel_bits(cnt_d[3:0]) | RD_M :
                 state_d == GO ? GO_M : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      res <= '0;
      err <= 1'b0;
      pin_data <= '0;
      pin_ctrl <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      sr <= sr_d;
      res <= res_d;
      err <= err_d;
      pin_data <= pin_data_d;
      pin_ctrl <= pin_ctrl_d;
    end
  end
endmodule

// File: tb/tb_chacha_qr_host.sv
// tb_chacha_qr_host: scoreboard bench for chacha_qr_host with a behavioural tile on the pins
module tb_chacha_qr_host;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_err, pin_busy;
  logic [31:0] in_a, in_b, in_c, in_d, out_a, out_b, out_c, out_d;
  logic [7:0] pin_data, pin_ctrl, pin_result;
  int checks = 0, failures = 0, cyc = 0;
  int busy_len = 2;
  bit stuck = 0;
  typedef struct {
    logic [31:0] a, b, c, d;
    logic err;
    int lat;
    int acc;
  } exp_t;
  exp_t sbq[$];

  chacha_qr_host dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d), .out_err(out_err),
    .pin_data(pin_data), .pin_ctrl(pin_ctrl), .pin_result(pin_result), .pin_busy(pin_busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
    a += b; d ^= a; d = {d[15:0], d[31:16]};
    c += d; b ^= c; b = {b[19:0], b[31:20]};
    a += b; d ^= a; d = {d[23:0], d[31:24]};
    c += d; b ^= c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  // behavioural tile: byte-addressed operand store, GO computes, RD registers a result byte
  logic [7:0] tmem [16];
  logic [127:0] tres;
  logic [3:0] tidx;
  int bcnt;
  assign tidx = {pin_ctrl[3:2], pin_ctrl[5:4]};
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_busy <= 0;
      pin_result <= 0;
      bcnt <= 0;
    end else begin
      if (pin_ctrl[0]) tmem[tidx] <= pin_data;
      if (pin_ctrl[6]) begin
        tres <= qr({tmem[3], tmem[2], tmem[1], tmem[0]}, {tmem[7], tmem[6], tmem[5], tmem[4]},
                   {tmem[11], tmem[10], tmem[9], tmem[8]}, {tmem[15], tmem[14], tmem[13], tmem[12]});
        pin_busy <= busy_len > 0;
        bcnt <= busy_len;
      end else if (pin_busy && !stuck) begin
        if (bcnt <= 1) pin_busy <= 0;
        else bcnt <= bcnt - 1;
      end
      if (pin_ctrl[1]) pin_result <= tres[int'(tidx)*8 +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, b, c, d, input logic err, input int lat);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.d = d; e.err = err; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // called at a negedge; returns at the negedge of the first LOAD cycle
  task automatic send(input logic [31:0] a, b, c, d, input bit push, input exp_t e);
    in_a = a; in_b = b; in_c = c; in_d = d; in_valid = 1;
    for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
    chk("accept_ready", 32'(in_ready), 32'd1);
    e.acc = cyc;
    if (push) sbq.push_back(e);
    @(negedge clk);
    in_valid = 0;
    in_a = '1; in_b = '1; in_c = '1; in_d = '1;
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && sbq.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  task automatic rst_pulse(input string nm);
    #2 rst = 1;
    #1;
    chk({nm, "_pin_ctrl"}, 32'(pin_ctrl), 32'd0);
    chk({nm, "_pin_data"}, 32'(pin_data), 32'd0);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  // monitor: first sight of out_valid checks latency, handshake checks values and stability
  bit seen = 0, bad = 0;
  logic [128:0] first;
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst) seen = 0;
    else if (out_valid) begin
      if (!seen) begin
        seen = 1; bad = 0;
        first = {out_err, out_d, out_c, out_b, out_a};
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out: got out_valid=1 expected no result");
        end else chk("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
      end else if ({out_err, out_d, out_c, out_b, out_a} != first) bad = 1;
      if (out_ready) begin
        seen = 0;
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("out_a", out_a, e.a);
          chk("out_b", out_b, e.b);
          chk("out_c", out_c, e.c);
          chk("out_d", out_d, e.d);
          chk("out_err", 32'(out_err), 32'(e.err));
          chk("out_stable", 32'(bad), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] RA = 32'h11111111, RB = 32'h01020304, RC = 32'h9b8d6f43, RD = 32'h01234567;
  localparam logic [31:0] XA = 32'hea2a92f4, XB = 32'hcb1cf8ce, XC = 32'h4581472e, XD = 32'h5881c4bb;

  initial begin
    logic [127:0] q;
    logic [7:0] tc [4];
    rst = 1; in_valid = 0; in_a = 0; in_b = 0; in_c = 0; in_d = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_pin_ctrl", 32'(pin_ctrl), 32'd0);
    chk("rst_pin_data", 32'(pin_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    send(RA, RB, RC, RD, 1, mk(XA, XB, XC, XD, 0, 38));
    drain();

    q = qr(32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c);
    send(32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c, 1, mk(q[31:0], q[63:32], q[95:64], q[127:96], 0, 38));
    tc[0] = 8'h01; tc[1] = 8'h11; tc[2] = 8'h21; tc[3] = 8'h31;
    for (int k = 0; k < 4; k++) begin
      chk("trace_ctrl", 32'(pin_ctrl), 32'(tc[k]));
      chk("trace_data", 32'(pin_data), 32'(k));
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("trace_go_ctrl", 32'(pin_ctrl), 32'h40);
    chk("trace_go_data", 32'(pin_data), 32'd0);
    drain();

    send(0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 38));
    drain();

    busy_len = 100;
    send(RA, RB, RC, RD, 1, mk(XA, XB, XC, XD, 0, 136));
    drain();
    busy_len = 2;

    stuck = 1;
    send(RA, RB, RC, RD, 1, mk(0, 0, 0, 0, 1, 1044));
    drain();
    stuck = 0;
    send(RA, RB, RC, RD, 1, mk(XA, XB, XC, XD, 0, 38));
    drain();

    out_ready = 0;
    send(RA, RB, RC, RD, 1, mk(XA, XB, XC, XD, 0, 38));
    for (int n = 0; n < 200 && !out_valid; n++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1;
    @(negedge clk);
    chk("after_accept_in_ready", 32'(in_ready), 32'd1);
    drain();

    send(RA, RB, RC, RD, 0, mk(0, 0, 0, 0, 0, 0));
    repeat (7) @(negedge clk);
    chk("mid_load_ctrl", 32'(pin_ctrl), 32'h35);
    chk("mid_load_data", 32'(pin_data), 32'h01);
    rst_pulse("load_rst");

    send(RA, RB, RC, RD, 0, mk(0, 0, 0, 0, 0, 0));
    repeat (25) @(negedge clk);
    chk("mid_read_ctrl", 32'(pin_ctrl), 32'h16);
    rst_pulse("read_rst");

    send(RA, RB, RC, RD, 1, mk(XA, XB, XC, XD, 0, 38));
    drain();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chacha_qr_host.md
Name: chacha_qr_host

Overview:
Host-side initiator for the ChaCha quarter-round tile's 8-bit pin protocol. It accepts four 32-bit words over a valid/ready port and serializes them as byte writes onto the tile's ui/uio pins. It then pulses GO, polls BUSY, reads back the 16 result bytes from uo_out, and presents the four result words on a valid/ready output port. It sits in the FPGA/co-sim harness on the far side of the tile pins and is the other end of the tile's byte interface.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles spent in WAIT before aborting with err=1
SETTLE_CYCLES, 2, cycles after GO before BUSY is sampled; minimum 1

Ports:
clk  in  1  single clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  high only in IDLE
in_a, in_b, in_c, in_d  in  32 each  quarter-round inputs a,b,c,d
out_valid  out  1  result valid; held until accepted
out_ready  in  1  result accept
out_a, out_b, out_c, out_d  out  32 each  quarter-round results
out_err  out  1  qualifies out_valid; 1 = timeout, results are all-zero
pin_data  out  8  drives tile ui_in
pin_ctrl  out  8  drives tile uio_in: [0]=WR, [1]=RD, [3:2]=word sel (0=a..3=d), [5:4]=byte sel, [6]=GO, [7]=0
pin_result  in  8  tile uo_out; holds the byte addressed by RD, valid the cycle after RD
pin_busy  in  1  tile uio_out[7]; high while computing

Behaviour:
- Reset (async assert, sync release): state=IDLE; pin_data=0, pin_ctrl=0, in_ready=0 while rst is high, out_valid=0, out_err=0, out_a..d=0, all counters 0. Reset mid-transaction aborts with no output. Pins return to 0 immediately.
- All pin outputs are registered. pin_ctrl[7] is always 0.
- Byte order is little-endian: byte sel 0 = bits [7:0].
- Word order is a, b, c, d. The index idx[3:0] = {word, byte}.
- IDLE: in_ready=1. When in_valid & in_ready, latch in_a..d into a 128-bit shift register, set idx=0, and go to LOAD.
- LOAD: 16 cycles. Each cycle drives WR=1, sel=idx, and pin_data = the addressed byte. At idx=15, go to GO.
- GO: 1 cycle with pin_ctrl = GO only (WR=0, pin_data=0). Load the settle counter and go to SETTLE.
- SETTLE: pins idle for SETTLE_CYCLES cycles, then go to WAIT. BUSY is ignored here.
- WAIT: pins idle. pin_busy is sampled each cycle.
  - If pin_busy=0, go to READ with idx=0.
  - The timeout counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 with busy still high, go to DONE with out_err=1 and results=0.
  - If busy falls on the same cycle the counter expires, READ wins.
- READ: 17 cycles, pipelined.
  - Cycle k (k=0..15) drives RD=1, sel=k.
  - Cycle k+1 captures pin_result into result byte k.
  - Cycle 16 drives RD=0 and captures byte 15, then goes to DONE.
- DONE: out_valid=1; out_a..d and out_err are stable. When out_valid & out_ready, go to IDLE on the next edge, clear out_valid, and keep out_* values until the next capture.
- Latency from accept to out_valid, when the tile drops busy at the first WAIT sample: 1+16+1+SETTLE_CYCLES+1+17 = 38 cycles with defaults. There are no back-to-back accepts; in_ready=0 outside IDLE.
- in_* values are ignored after the accept cycle. Changes to in_valid outside IDLE have no effect.

Decomposition:
- Package chacha_qr_pkg holds:
  - state enum (IDLE, LOAD, GO, SETTLE, WAIT, READ, DONE)
  - pin_ctrl bit-position constants (CTRL_WR=0, CTRL_RD=1, CTRL_SEL_LSB=2, CTRL_BYTE_LSB=4, CTRL_GO=6)
  - word-index constants
- No sub-module: the FSM, shift/capture registers and counters live in one module.
- The bench provides a behavioural tile model that is reused by the tile's own tests.

Test Plan:
- RFC 7539 §2.1.1 vector: in a=0x11111111 b=0x01020304 c=0x9b8d6f43 d=0x01234567 -> out a=0xea2a92f4 b=0xcb1cf8ce c=0x4581472e d=0x5881c4bb, out_err=0, out_valid at cycle 38.
- Pin trace check for in_a=0x03020100: first four LOAD cycles -> pin_ctrl=0x01,0x11,0x21,0x31 with pin_data=0x00,0x01,0x02,0x03; next cycle after LOAD -> GO pin_ctrl=0x40.
- Tile holds busy for 100 cycles -> READ starts the cycle after busy falls; correct results; no err.
- Busy stuck high -> out_valid with out_err=1, results 0, exactly TIMEOUT_CYCLES cycles after WAIT entry; next request then succeeds.
- out_ready held low 20 cycles in DONE -> out_valid and out_* stable, in_ready=0; accepting returns to IDLE with in_ready=1 the next cycle.
- rst pulsed mid-LOAD (idx=7) and mid-READ -> pins=0 and out_valid=0 asynchronously; a subsequent RFC vector completes correctly.
